mux4_rr_collector: RTL and testbench

- Reverse-direction partner of the team's 1-to-4 demultiplexer. It gathers 2-bit beats from four source channels W, X, Y and Z onto one output stream.
- Each output beat is tagged with a 2-bit SEL giving the source channel, so the downstream demultiplexer can route it back.
- Channels are granted round-robin over a valid/ready handshake, and the output is registered.

---
 rtl/mux_pkg.sv | 36 +++
 rtl/rr_arb4.sv | 65 ++++++
 rtl/mux4_rr_collector.sv | 133 +++++++++++++
 tb/tb_mux4_rr_collector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the 4-to-1 round-robin collector (mux4_rr_collector)
// and its arbiter (rr_arb4).
//
// Contents:
//   NUM_CH          number of source channels (W, X, Y, Z)
//   SEL_W           width of a channel index / output tag
//   sel_t           channel index type
//   CH_W..CH_Z      channel index constants
//   ch_onehot()     index -> one-hot request/grant vector
//
// Configuration macro: MUX4_FIXED_PRIO_EN (used by rr_arb4 and the top).
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t CH_W = 2'd0;
    localparam sel_t CH_X = 2'd1;
    localparam sel_t CH_Y = 2'd2;
    localparam sel_t CH_Z = 2'd3;

    // Turns a channel index into the matching single-bit position of a
    // NUM_CH-wide vector, so grants and in_ready share one encoding.
    function automatic logic [NUM_CH-1:0] ch_onehot(input sel_t idx);
        logic [NUM_CH-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// ---------------------------------------------------------------------------
// rr_arb4
// Purely combinational 4-way arbiter for mux4_rr_collector.
//
// Default build: round-robin. Requests are scanned starting at 'ptr' and
// moving upward modulo 4; the first requesting channel wins.
// With MUX4_FIXED_PRIO_EN defined: fixed priority W > X > Y > Z, the 'ptr'
// port does not exist and the scan always starts at channel 0.
//
// Ports:
//   req        [3:0]  request vector, bit i = channel i wants a slot
//   ptr        sel_t  first channel to consider (round-robin build only)
//   gnt_onehot [3:0]  one-hot grant, all zero when nothing is requested
//   gnt_idx    sel_t  index of the granted channel (0 when gnt_any = 0)
//   gnt_any           at least one request is present
// ---------------------------------------------------------------------------
module rr_arb4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
`ifndef MUX4_FIXED_PRIO_EN
    input  sel_t              ptr,
`endif
    output logic [NUM_CH-1:0] gnt_onehot,
    output sel_t              gnt_idx,
    output logic              gnt_any
);

    sel_t start;

    // Scan origin: the rotating pointer in round-robin mode, channel W when
    // priority is fixed.
`ifdef MUX4_FIXED_PRIO_EN
    assign start = CH_W;
`else
    assign start = ptr;
`endif

    // Walk the offsets from the farthest to the nearest so that the last
    // hit written is the channel closest to 'start'. The 2-bit addition
    // wraps naturally, giving the modulo-4 scan order.
    always_comb begin
        sel_t cand;
        gnt_any = 1'b0;
        gnt_idx = CH_W;
        cand    = CH_W;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = start + sel_t'(k);
            if (req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // The one-hot form is derived from the index so the two can never
    // disagree.
    always_comb begin
        gnt_onehot = '0;
        if (gnt_any) begin
            gnt_onehot = ch_onehot(gnt_idx);
        end
    end

endmodule

// File: rtl/mux4_rr_collector.sv
// ---------------------------------------------------------------------------
// mux4_rr_collector
// Collects DATA_W-bit beats from four source channels (W, X, Y, Z) onto a
// single registered output stream. Every output beat carries a SEL tag with
// its source channel so a downstream 1-to-4 demultiplexer can route it back.
// Channels are granted over valid/ready; the output register is refilled in
// the same cycle it drains, so a continuous stream runs at 1 beat/cycle.
//
// Parameters:
//   DATA_W   width of each channel and of A            (default 2)
//   CNT_W    width of the accepted-beat counter        (default 8)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   W,X,Y,Z    channel 0..3 data
//   in_valid   bit i: channel i presents a beat
//   in_ready   bit i: channel i beat accepted this cycle (at most one set)
//   A          registered output data
//   SEL        registered source index of A
//   out_valid  A/SEL hold a beat
//   out_ready  downstream accepts the beat
//   beat_cnt   number of beats accepted from the inputs (wraps)
//
// Configuration macro: MUX4_FIXED_PRIO_EN
//   undefined (default): round-robin arbitration with a rotating pointer
//   defined            : fixed priority W > X > Y > Z, no pointer register
// ---------------------------------------------------------------------------
module mux4_rr_collector
    import mux_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] W,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] Y,
    input  logic [DATA_W-1:0] Z,
    input  logic [NUM_CH-1:0] in_valid,
    output logic [NUM_CH-1:0] in_ready,
    output logic [DATA_W-1:0] A,
    output sel_t              SEL,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  beat_cnt
);

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [NUM_CH-1:0] gnt_onehot;
    sel_t              gnt_idx;
    logic              gnt_any;
    logic              load_ok;
    logic              accept;

    assign ch_data[CH_W] = W;
    assign ch_data[CH_X] = X;
    assign ch_data[CH_Y] = Y;
    assign ch_data[CH_Z] = Z;

`ifndef MUX4_FIXED_PRIO_EN
    sel_t rr_ptr;

    rr_arb4 u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );
`else
    rr_arb4 u_arb (
        .req        (in_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );
`endif

    // The output register can take a new beat when it is empty or when its
    // current beat leaves in this same cycle; that second case is what
    // removes the bubble between back-to-back beats.
    assign load_ok = !out_valid || out_ready;

    // Ready goes only to the granted channel, and only when the register can
    // load. It is also forced low while reset is asserted so no source sees
    // a handshake that the held-in-reset register would then drop.
    always_comb begin
        in_ready = '0;
        if (rst_n && gnt_any && load_ok) begin
            in_ready = gnt_onehot;
        end
    end

    // The grant always targets a requesting channel, so a granted ready is
    // already a completed handshake.
    assign accept = |(in_valid & in_ready);

    // Output register and beat counter. An accepted beat overwrites the
    // register (whether it was empty or draining). A drain with no refill
    // only clears out_valid; A and SEL keep their last values. A stall holds
    // everything because accept is impossible while load_ok is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A         <= '0;
            SEL       <= CH_W;
            out_valid <= 1'b0;
            beat_cnt  <= '0;
        end else if (accept) begin
            A         <= ch_data[gnt_idx];
            SEL       <= gnt_idx;
            out_valid <= 1'b1;
            beat_cnt  <= beat_cnt + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef MUX4_FIXED_PRIO_EN
    // After a grant the scan restarts just past the winner, so every other
    // waiting channel gets served before the winner is considered again.
    // The 2-bit increment wraps Z back to W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= CH_W;
        end else if (accept) begin
            rr_ptr <= gnt_idx + sel_t'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mux4_rr_collector.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_collector
// Scoreboard bench for mux4_rr_collector. The stimulus side computes the
// expected grant from the arbitration rules and pushes each accepted beat
// ({data, source}) into a queue; a monitor on the falling edge compares the
// DUT output register against the queue head and pops on every handshake.
// Honours MUX4_FIXED_PRIO_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mux4_rr_collector;

    localparam int DATA_W = 2;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] W, X, Y, Z;
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [DATA_W-1:0] A;
    logic [1:0]        SEL;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  beat_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_q [$];
    int         model_ptr = 0;
    int         model_cnt = 0;
    logic [3:0] exp_ready = 4'b0;

    always #5 clk = ~clk;

    mux4_rr_collector #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .SEL       (SEL),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    // One comparison: counts it, reports a failure with both values.
    task automatic checkOutput(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs (just after a rising edge), works out the
    // expected grant from the rules, checks in_ready and the counter at the
    // falling edge, and records the accepted beat at the next rising edge.
    task automatic applyStimulus(input logic [3:0] v,
                                 input logic [1:0] dw, input logic [1:0] dx,
                                 input logic [1:0] dy, input logic [1:0] dz,
                                 input logic ordy);
        logic [1:0] d [4];
        int         g;
        int         start;
        logic       load_ok;
        #1;
        in_valid  = v;
        W         = dw;
        X         = dx;
        Y         = dy;
        Z         = dz;
        out_ready = ordy;
        d[0] = dw; d[1] = dx; d[2] = dy; d[3] = dz;
`ifdef MUX4_FIXED_PRIO_EN
        start = 0;
`else
        start = model_ptr;
`endif
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (g < 0 && v[c]) g = c;
        end
        load_ok   = (exp_q.size() == 0) || ordy;
        exp_ready = (g >= 0 && load_ok) ? 4'(1 << g) : 4'b0;
        @(negedge clk);
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("beat_cnt", 32'(beat_cnt), model_cnt);
        @(posedge clk);
        if (exp_ready != 4'b0) begin
            exp_q.push_back({d[g], 2'(g)});
            model_ptr = (g + 1) % 4;
            model_cnt = (model_cnt + 1) % 256;
        end
    endtask

    // Asserts reset between clock edges, checks that the output register
    // clears without waiting for a clock, then releases on a falling edge.
    task automatic doReset();
        #2;
        in_valid = 4'b1111;
        rst_n    = 1'b0;
        #1;
        checkOutput("rst A", 32'(A), 0);
        checkOutput("rst SEL", 32'(SEL), 0);
        checkOutput("rst out_valid", 32'(out_valid), 0);
        checkOutput("rst beat_cnt", 32'(beat_cnt), 0);
        checkOutput("rst in_ready", 32'(in_ready), 0);
        exp_q.delete();
        model_ptr = 0;
        model_cnt = 0;
        in_valid  = 4'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // Monitor: whenever the queue holds a beat the DUT must show it; the
    // beat leaves the queue on the handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("out_valid", 32'(out_valid), (exp_q.size() != 0) ? 1 : 0);
            if (exp_q.size() != 0) begin
                if (out_valid) begin
                    checkOutput("A/SEL", 32'({A, SEL}), 32'(exp_q[0]));
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [1:0] cd [4];
        logic [3:0] cv;

        W = '0; X = '0; Y = '0; Z = '0;
        in_valid  = 4'b0;
        out_ready = 1'b0;
        @(posedge clk);
        doReset();

        // Single channel X
        applyStimulus(4'b0010, 2'd0, 2'b01, 2'd0, 2'd0, 1'b1);
        #1;
        checkOutput("single SEL", 32'(SEL), 1);
        checkOutput("single A", 32'(A), 1);
        checkOutput("single cnt", 32'(beat_cnt), 1);
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

        // All four channels valid, data equal to channel index
        doReset();
        repeat (8) applyStimulus(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
        #1;
        checkOutput("rr beat_cnt", 32'(beat_cnt), 8);
        applyStimulus(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
        // Reset while the output register holds a beat
        doReset();

        // Backpressure: load Z, stall three cycles with W waiting, release
        applyStimulus(4'b1000, 2'd0, 2'd0, 2'd0, 2'b11, 1'b0);
        repeat (3) applyStimulus(4'b0001, 2'b10, 2'd0, 2'd0, 2'b11, 1'b0);
        #1;
        checkOutput("stall A", 32'(A), 3);
        checkOutput("stall SEL", 32'(SEL), 3);
        applyStimulus(4'b0001, 2'b10, 2'd0, 2'd0, 2'b11, 1'b1);
        #1;
        checkOutput("nobubble SEL", 32'(SEL), 0);
        checkOutput("nobubble valid", 32'(out_valid), 1);
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

        // Counter wrap
        doReset();
        repeat (255) applyStimulus(4'b1111, 2'($urandom), 2'($urandom),
                                   2'($urandom), 2'($urandom), 1'b1);
        #1;
        checkOutput("cnt 255", 32'(beat_cnt), 255);
        applyStimulus(4'b0100, 2'd0, 2'd0, 2'($urandom), 2'd0, 1'b1);
        #1;
        checkOutput("cnt wrap", 32'(beat_cnt), 0);
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

`ifdef MUX4_FIXED_PRIO_EN
        doReset();
        repeat (4) begin
            applyStimulus(4'b1111, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
            #1;
            checkOutput("fixed SEL", 32'(SEL), 0);
        end
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
`endif

        // Random traffic: a waiting source keeps its data, may drop valid
        doReset();
        cv = 4'b0;
        for (int i = 0; i < 4; i++) cd[i] = 2'($urandom);
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (cv[i] && !exp_ready[i]) begin
                    if ($urandom_range(7, 0) == 0) cv[i] = 1'b0;
                end else begin
                    cv[i] = 1'($urandom);
                    cd[i] = 2'($urandom);
                end
            end
            applyStimulus(cv, cd[0], cd[1], cd[2], cd[3],
                          ($urandom_range(3, 0) != 0));
        end
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        applyStimulus(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
